// File: rtl/pipe_hazard_scheduler.sv
// rtl/pipe_hazard_scheduler.sv - issue/hazard scheduler with 4-slot scoreboard and branch sequencing
// Optional perf counters built when HAZ_PERF_EN is defined.
module pipe_hazard_scheduler #(
  parameter int NREG     = 8,
  parameter int SB_DEPTH = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  input  logic [2:0]  cc_in,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [9:0]  pc_delta,
  output logic [15:0] id_instr,
  output logic        stall,
  output logic [15:0] perf_stall,
  output logic [15:0] perf_br,
  output logic [15:0] perf_issue
);

  localparam int RW = $clog2(NREG);

  typedef enum logic {RUN, BR_WAIT} state_t;

  state_t              state;
  logic [SB_DEPTH-1:0] sb_valid;
  logic [RW-1:0]       sb_dest [SB_DEPTH];
  logic [2:0]          br_nzp;
  logic [8:0]          br_off;

  logic [3:0]    opcode;
  logic [RW-1:0] f_hi, f_mid, f_lo;
  logic          is_writer, is_cbr, rd_hi, rd_mid, rd_lo;
  logic          hazard, older_busy, taken, issue;
  logic          unused_bits;

  assign opcode      = if_instr[15:12];
  assign f_hi        = if_instr[9 +: RW];
  assign f_mid       = if_instr[6 +: RW];
  assign f_lo        = if_instr[0 +: RW];
  assign is_writer   = (opcode == 4'd1) || (opcode == 4'd6);
  assign is_cbr      = (opcode == 4'd0) && (if_instr[11:9] != 3'b000);
  assign rd_hi       = (opcode == 4'd7);
  assign rd_mid      = (opcode == 4'd1) || (opcode == 4'd6) || (opcode == 4'd7);
  assign rd_lo       = (opcode == 4'd1) && !if_instr[5];
  assign unused_bits = ^if_instr[4:3];

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (sb_valid[k] && ((rd_hi  && sb_dest[k] == f_hi)  ||
                          (rd_mid && sb_dest[k] == f_mid) ||
                          (rd_lo  && sb_dest[k] == f_lo)))
        hazard = 1'b1;
    end
  end

  // CC is final once no writer remains ahead of WB
  assign older_busy = |sb_valid[2:0];
  assign taken      = |(br_nzp & cc_in);

  always_comb begin
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    pc_delta = 10'd0;
    stall    = 1'b0;
    issue    = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (if_valid) begin
            if (hazard) begin
              stall = 1'b1;
            end else if (!is_cbr) begin
              issue  = 1'b1;
              pc_inc = 1'b1;
            end
          end
        end
        BR_WAIT: begin
          if (!older_busy) begin
            pc_load  = 1'b1;
            pc_delta = taken ? ({br_off[8], br_off} + 10'd1) : 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= RUN;
      sb_valid <= '0;
      for (int k = 0; k < SB_DEPTH; k++) sb_dest[k] <= '0;
      id_instr <= 16'h0000;
      br_nzp   <= 3'b000;
      br_off   <= 9'd0;
    end else begin
      for (int k = SB_DEPTH - 1; k > 0; k--) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_dest[k]  <= sb_dest[k-1];
      end
      sb_valid[0] <= issue && is_writer;
      sb_dest[0]  <= (issue && is_writer) ? if_instr[9 +: RW] : '0;
      id_instr    <= issue ? if_instr : 16'h0000;
      case (state)
        RUN: begin
          if (if_valid && !hazard && is_cbr) begin
            state  <= BR_WAIT;
            br_nzp <= if_instr[11:9];
            br_off <= if_instr[8:0];
          end
        end
        BR_WAIT: begin
          if (pc_load) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_EN
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      perf_stall <= 16'd0;
      perf_br    <= 16'd0;
      perf_issue <= 16'd0;
    end else begin
      if (stall && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 16'd1;
      if (state == BR_WAIT && perf_br != 16'hFFFF) perf_br <= perf_br + 16'd1;
      if (pc_inc && perf_issue != 16'hFFFF) perf_issue <= perf_issue + 16'd1;
    end
  end
`else
  assign perf_stall = 16'd0;
  assign perf_br    = 16'd0;
  assign perf_issue = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_scheduler.sv
// tb/tb_pipe_hazard_scheduler.sv - directed self-checking bench for pipe_hazard_scheduler
module tb_pipe_hazard_scheduler;

`ifdef HAZ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        reset, if_valid;
  logic [15:0] if_instr;
  logic [2:0]  cc_in;
  logic        pc_inc, pc_load, stall;
  logic [9:0]  pc_delta;
  logic [15:0] id_instr, perf_stall, perf_br, perf_issue;

  int ntests = 0;
  int nfail  = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  pipe_hazard_scheduler #(.NREG(8), .SB_DEPTH(4)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
    .cc_in(cc_in), .pc_inc(pc_inc), .pc_load(pc_load), .pc_delta(pc_delta),
    .id_instr(id_instr), .stall(stall), .perf_stall(perf_stall),
    .perf_br(perf_br), .perf_issue(perf_issue)
  );

  task automatic edge_step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; if_valid = 1'b0; if_instr = 16'h0000; cc_in = 3'b000;
    edge_step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_valid = 1'b1; if_instr = 16'h1283; cc_in = 3'b000;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLOCK_50);
      ntests++;
      if ({pc_inc, pc_load, stall} !== 3'b000) begin
        nfail++; $display("FAIL reset_ctl[%0d]: got %b exp 000", i, {pc_inc, pc_load, stall});
      end
      if (i == 1) begin
        ntests++;
        if (id_instr !== 16'h0000) begin
          nfail++; $display("FAIL reset_id: got %h exp 0000", id_instr);
        end
      end
      edge_step();
    end
    reset = 1'b0;
    @(negedge CLOCK_50);
    ntests++;
    if (pc_inc !== 1'b1 || pc_load !== 1'b0) begin
      nfail++; $display("FAIL reset_release: pc_inc=%b pc_load=%b exp 1 0", pc_inc, pc_load);
    end
    ntests++;
    if ({perf_stall, perf_br, perf_issue} !== 48'd0) begin
      nfail++; $display("FAIL reset_perf: got %h %h %h exp 0", perf_stall, perf_br, perf_issue);
    end
    edge_step();
    @(negedge CLOCK_50);
    ntests++;
    if (id_instr !== 16'h1283) begin
      nfail++; $display("FAIL reset_first_issue: got %h exp 1283", id_instr);
    end
  endtask

  task automatic test_raw();
    int n;
    do_reset();
    if_valid = 1'b1; if_instr = 16'h1283;
    edge_step();
    if_instr = 16'h1861;
    n = 0;
    @(negedge CLOCK_50);
    while (stall === 1'b1 && n < 10) begin
      n++;
      ntests++;
      if (id_instr !== (n == 1 ? 16'h1283 : 16'h0000) || pc_inc !== 1'b0) begin
        nfail++; $display("FAIL raw_bubble[%0d]: id=%h pc_inc=%b", n, id_instr, pc_inc);
      end
      edge_step();
      @(negedge CLOCK_50);
    end
    ntests++;
    if (n !== 4 || pc_inc !== 1'b1) begin
      nfail++; $display("FAIL raw_stall_count: got %0d pc_inc=%b exp 4 1", n, pc_inc);
    end
    edge_step();
    if_valid = 1'b0;
    @(negedge CLOCK_50);
    ntests++;
    if (id_instr !== 16'h1861) begin
      nfail++; $display("FAIL raw_issue: got %h exp 1861", id_instr);
    end
    ntests++;
    if (perf_stall !== (PERF ? 16'd4 : 16'd0) || perf_issue !== (PERF ? 16'd2 : 16'd0)) begin
      nfail++; $display("FAIL raw_perf: stall=%0d issue=%0d", perf_stall, perf_issue);
    end
  endtask

  task automatic test_st_hazard();
    int n;
    do_reset();
    if_valid = 1'b1; if_instr = 16'h1283;
    edge_step();
    if_instr = 16'h7280;
    n = 0;
    @(negedge CLOCK_50);
    while (stall === 1'b1 && n < 10) begin
      n++;
      edge_step();
      @(negedge CLOCK_50);
    end
    ntests++;
    if (n !== 4 || pc_inc !== 1'b1) begin
      nfail++; $display("FAIL st_stall_count: got %0d pc_inc=%b exp 4 1", n, pc_inc);
    end
    edge_step();
    if_instr = 16'h7000;
    @(negedge CLOCK_50);
    ntests++;
    if (stall !== 1'b0 || pc_inc !== 1'b1) begin
      nfail++; $display("FAIL st_nohaz: stall=%b pc_inc=%b exp 0 1", stall, pc_inc);
    end
  endtask

  task automatic test_self_dep();
    do_reset();
    if_valid = 1'b1; if_instr = 16'h1261;
    @(negedge CLOCK_50);
    ntests++;
    if (stall !== 1'b0 || pc_inc !== 1'b1) begin
      nfail++; $display("FAIL self_dep_issue: stall=%b pc_inc=%b exp 0 1", stall, pc_inc);
    end
    edge_step();
    @(negedge CLOCK_50);
    ntests++;
    if (stall !== 1'b1 || pc_inc !== 1'b0) begin
      nfail++; $display("FAIL self_dep_older: stall=%b pc_inc=%b exp 1 0", stall, pc_inc);
    end
  endtask

  task automatic test_taken_branch();
    int n;
    do_reset();
    if_valid = 1'b1; if_instr = 16'h1283;
    edge_step();
    if_instr = 16'h0805;
    @(negedge CLOCK_50);
    ntests++;
    if ({pc_inc, pc_load, stall} !== 3'b000) begin
      nfail++; $display("FAIL br_accept: got %b exp 000", {pc_inc, pc_load, stall});
    end
    edge_step();
    if_instr = 16'h1283;
    cc_in = 3'b100;
    n = 0;
    @(negedge CLOCK_50);
    while (pc_load !== 1'b1 && n < 10) begin
      n++;
      ntests++;
      if (pc_inc !== 1'b0 || id_instr === 16'h0805) begin
        nfail++; $display("FAIL br_wait[%0d]: pc_inc=%b id=%h", n, pc_inc, id_instr);
      end
      edge_step();
      @(negedge CLOCK_50);
    end
    ntests++;
    if (n !== 2 || pc_delta !== 10'd6 || pc_inc !== 1'b0) begin
      nfail++; $display("FAIL br_taken: waits=%0d delta=%0d pc_inc=%b exp 2 6 0", n, pc_delta, pc_inc);
    end
    edge_step();
    @(negedge CLOCK_50);
    ntests++;
    if (pc_load !== 1'b0 || pc_inc !== 1'b1 || perf_br !== (PERF ? 16'd3 : 16'd0)) begin
      nfail++; $display("FAIL br_return: pc_load=%b pc_inc=%b perf_br=%0d", pc_load, pc_inc, perf_br);
    end
  endtask

  task automatic test_not_taken();
    do_reset();
    if_valid = 1'b1; if_instr = 16'h0405; cc_in = 3'b001;
    edge_step();
    @(negedge CLOCK_50);
    ntests++;
    if (pc_load !== 1'b1 || pc_delta !== 10'd1) begin
      nfail++; $display("FAIL br_not_taken: pc_load=%b delta=%0d exp 1 1", pc_load, pc_delta);
    end
    edge_step();
    if_instr = 16'h0FFF; cc_in = 3'b010;
    edge_step();
    @(negedge CLOCK_50);
    ntests++;
    if (pc_load !== 1'b1 || pc_delta !== 10'd0) begin
      nfail++; $display("FAIL br_neg_off: pc_load=%b delta=%h exp 1 000", pc_load, pc_delta);
    end
    edge_step();
    if_instr = 16'h0000;
    @(negedge CLOCK_50);
    ntests++;
    if (pc_inc !== 1'b1 || pc_load !== 1'b0 || pc_delta !== 10'd0) begin
      nfail++; $display("FAIL nop_adv: pc_inc=%b pc_load=%b delta=%h", pc_inc, pc_load, pc_delta);
    end
    edge_step();
    @(negedge CLOCK_50);
    ntests++;
    if (id_instr !== 16'h0000) begin
      nfail++; $display("FAIL nop_id: got %h exp 0000", id_instr);
    end
  endtask

  task automatic test_reset_in_br();
    do_reset();
    if_valid = 1'b1; if_instr = 16'h0805; cc_in = 3'b100;
    edge_step();
    reset = 1'b1;
    @(negedge CLOCK_50);
    ntests++;
    if (pc_load !== 1'b0 || pc_delta !== 10'd0) begin
      nfail++; $display("FAIL rst_br_load: pc_load=%b delta=%h exp 0 000", pc_load, pc_delta);
    end
    edge_step();
    reset = 1'b0; if_instr = 16'h1283;
    @(negedge CLOCK_50);
    ntests++;
    if (pc_inc !== 1'b1 || pc_load !== 1'b0) begin
      nfail++; $display("FAIL rst_br_run: pc_inc=%b pc_load=%b exp 1 0", pc_inc, pc_load);
    end
    edge_step();
    @(negedge CLOCK_50);
    ntests++;
    if (id_instr !== 16'h1283) begin
      nfail++; $display("FAIL rst_br_issue: got %h exp 1283", id_instr);
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_st_hazard();
    test_self_dep();
    test_taken_branch();
    test_not_taken();
    test_reset_in_br();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_scheduler.md
# pipe_hazard_scheduler

Issue and hazard controller placed between instruction fetch and operand fetch of the 5-stage 16-bit pipeline. It tracks destination registers in flight with a 4-slot scoreboard covering ID, EX, MEM and WB. Using that scoreboard it decides each cycle whether to issue the fetched word, insert a bubble, or hold the PC. It also sequences conditional branches: it waits until CC is final, then tells the PC to load the resolved target.

## Interface
- `NREG`, 8: architectural register count; register fields are 3 bits.
- `SB_DEPTH`, 4: scoreboard slots for ID, EX, MEM, WB. Fixed at 4; other values are unsupported.
- `CLOCK_50` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `if_valid` in 1: `if_instr` holds a fetched word.
- `if_instr` in 16: instruction at the current PC.
- `cc_in` in 3: {n,z,p} from the MEM stage; updated at the end of MEM.
- `pc_inc` out 1: PC advances by 1 at the next edge.
- `pc_load` out 1: PC adds `pc_delta` at the next edge; takes priority over `pc_inc`.
- `pc_delta` out 10: signed PC adjustment, valid while `pc_load`=1.
- `id_instr` out 16: registered word into ID; 0x0000 means a bubble.
- `stall` out 1: hazard stall this cycle.
- `perf_stall`, `perf_br`, `perf_issue` out 16 each: performance counters (see Configuration).

## Operation
- Decode of `if_instr`:
  - Opcode [15:12].
  - ADD (1): writes [11:9]. Reads [8:6], and also [2:0] when bit5=0.
  - LD (6): writes [11:9]. Reads [8:6].
  - ST (7): reads [11:9] and [8:6].
  - BR (0) with nzp [11:9] ≠ 0: reads nothing. Offset is [8:0], signed.
  - Opcode 0 with nzp=0, and any other opcode: NOP. No reads, no writes.
- Writers: ADD and LD. Every writer also updates CC.
- Scoreboard:
  - Slot k holds {valid, dest[2:0]}.
  - Every edge: slot3←slot2, slot2←slot1, slot1←slot0.
  - slot0←{1, dest} when a writer issues; otherwise slot0←{0, 0}.
- Hazard: any read register of `if_instr` equals the dest of any valid slot 0..3.
- States:
  - RUN:
    - `if_valid`=0: `id_instr`←0, PC held.
    - Hazard: `stall`=1, `id_instr`←0, PC held.
    - Conditional BR: `id_instr`←0, PC held, latch nzp/offset, go to BR_WAIT. The branch never enters ID.
    - Otherwise: `id_instr`←`if_instr`, `pc_inc`=1. NOPs also advance the PC.
  - BR_WAIT:
    - PC held and `id_instr`←0 while any of slots 0..2 is valid.
    - Once slots 0..2 are all invalid: `pc_load`=1 and return to RUN.
      - Taken = |(nzp & `cc_in`).
      - `pc_delta` = sext(offset)+1 if taken, else +1.
      - The PC still points at the branch, so +1 gives the fall-through address.
- Arithmetic: sext(offset) is a 9→10 bit sign extension. The +1 never overflows 10 bits: range −255..+256.
- `pc_inc`, `pc_load`, `pc_delta` and `stall` are combinational from state, scoreboard, `if_instr` and `cc_in`. `id_instr` and the scoreboard are registered.
- Only one of `pc_inc`/`pc_load` is ever high.

## Timing
- Reset values:
  - State RUN; all slots invalid.
  - `id_instr`=0x0000, all counters 0.
  - `pc_inc`, `pc_load`, `stall` are 0 in the reset cycle.
  - `pc_delta`=0 whenever `pc_load`=0.
- Issue latency: word issued at edge t appears on `id_instr` after edge t.
- RAW penalty: a dependent instruction immediately after its producer stalls 4 cycles and issues in cycle t+5.
- Branch penalty:
  - Minimum 2 cycles: the accept cycle plus one BR_WAIT cycle with `pc_load`.
  - Plus one cycle for every cycle a CC writer remains in slots 0..2.
- Boundaries:
  - `reset` during BR_WAIT: the branch is dropped, state goes to RUN, no `pc_load`.
  - `if_valid` is ignored in BR_WAIT.
  - The scoreboard keeps shifting during stalls; bubbles enter slot0.
  - An issuing writer whose dest matches its own source (e.g. ADD R1,R1,#1) is not a hazard, provided no older in-flight writer targets R1.

## Configuration
- `HAZ_PERF_EN` defined: three saturating 16-bit counters, cleared by `reset`, saturating at 0xFFFF.
  - `perf_stall`: counts cycles with `stall`=1.
  - `perf_br`: counts cycles spent in BR_WAIT.
  - `perf_issue`: counts cycles with `pc_inc`=1.
- `HAZ_PERF_EN` undefined: the counters are not built and the three outputs are tied to 0.

## Test plan
- Reset: assert `reset` 2 cycles with `if_instr`=0x1283 → `id_instr`=0, `pc_inc`=0, `pc_load`=0, counters 0. First release cycle → `pc_inc`=1; next edge `id_instr`=0x1283.
- RAW: 0x1283 (ADD R1,R2,R3) then 0x1861 (ADD R4,R1,#1) → `stall`=1 for exactly 4 cycles; 0x1861 reaches `id_instr` 5 edges after 0x1283; `perf_stall`=4.
- ST source hazard: 0x1283 then 0x7440 (ST R2? no—ST R1 at [R2]: 0x7280) → 4 stall cycles. 0x7000 with no writers in flight → issues with no stall.
- Taken branch: 0x1283 with `cc_in`=100 at MEM exit, then 0x0805 (BRn +5) → BR_WAIT holds while ADD is in slots 0..2, then `pc_load`=1 with `pc_delta`=+6. The branch never appears on `id_instr`.
- Not taken / NOP: 0x0405 (BRz) with `cc_in`=001 and an empty scoreboard → `pc_load` in the second cycle with `pc_delta`=+1. 0x0000 → `pc_inc`=1, `id_instr`=0.
- Reset in BR_WAIT: assert `reset` in the first BR_WAIT cycle → no `pc_load`; state RUN; next valid ADD issues normally.
